// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file.
// Holds the default geometry and the clear-sequencer state type.
package regfile_pkg;

  localparam int DW_DEF = 4;
  localparam int AW_DEF = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer for regfile_param.
// Walks a pointer across all 2**AW entries, one per cycle, and emits a
// clear-write strobe plus address. clr_done pulses in the first idle
// cycle after the last entry has been zeroed.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST_ADDR = '1;

  clr_state_t    state;
  logic [AW-1:0] ptr;

  // FSM, pointer and registered status flags.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clr_req) begin
            state    <= ST_CLEAR;
            ptr      <= '0;
            clr_busy <= 1'b1;
          end
        end
        ST_CLEAR: begin
          // clr_req is ignored here: no restart, no queueing.
          ptr <= ptr + 1'b1;
          if (ptr == LAST_ADDR) begin
            state    <= ST_IDLE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // clr_busy is high exactly while in CLEAR, so it doubles as the write strobe.
  assign clr_we   = clr_busy;
  assign clr_addr = ptr;

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: 2**AW x DW, two combinational read ports,
// one write port with same-cycle write-through bypass, and a hardware
// clear sequencer that zeroes one entry per cycle.
// Optional build macro REGFILE_ZERO_REG_EN hardwires register 0 to zero.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] sa,
  input  logic [AW-1:0] sb,
  output logic [DW-1:0] a,
  output logic [DW-1:0] b,
  input  logic [DW-1:0] d,
  input  logic [AW-1:0] da,
  input  logic          w,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          wr_drop
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];
  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          user_we;
  logic          bypass_en;

  regfile_clr_seq #(.AW(AW)) u_clr_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // User writes are only accepted while idle; register 0 may be read-only.
`ifdef REGFILE_ZERO_REG_EN
  assign user_we = w & ~clr_busy & (da != '0);
`else
  assign user_we = w & ~clr_busy;
`endif

  assign wr_drop = w & clr_busy;

  // Bypass is suppressed during reset so the read ports show the cleared array.
  assign bypass_en = user_we & rst_n;

  // Storage array with a clear-write / user-write mux; clear has priority.
  // NOTE: the array is reset because a reset must leave every entry readable as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (user_we) begin
      mem[da] <= d;
    end
  end

  // Read muxes with write-through bypass.
  // NOTE: combinational outputs get a default first so no path infers a latch.
  always_comb begin
    a = mem[sa];
    b = mem[sb];
    if (bypass_en && (da == sa)) a = d;
    if (bypass_en && (da == sb)) b = d;
`ifdef REGFILE_ZERO_REG_EN
    if (sa == '0) a = '0;
    if (sb == '0) b = '0;
`endif
  end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised register file: DEPTH = 2**AW registers, each DW bits wide, two combinational read ports (A, B) and one write port.
- Adds same-cycle write-through bypass and a hardware clear sequencer that zeroes the array one entry per cycle.
- Sits in the datapath between the ALU result bus (D) and the ALU operand buses (A, B).
- Driven by the control unit's select, destination and write-enable signals.

Parameters:
- DW, 4, data width in bits.
- AW, 3, address width; DEPTH = 2**AW registers.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- sa  in  AW  A-port read address.
- sb  in  AW  B-port read address.
- a  out  DW  A-port read data.
- b  out  DW  B-port read data.
- d  in  DW  write data.
- da  in  AW  write destination address.
- w  in  1  write enable.
- clr_req  in  1  request a full clear (one-cycle pulse or level).
- clr_busy  out  1  clear sequence in progress.
- clr_done  out  1  one-cycle pulse when the clear completes.
- wr_drop  out  1  a write was rejected this cycle.

Behaviour:
- Reset: rst_n low asynchronously forces all registers to 0, FSM to IDLE, clear pointer to 0, clr_busy=0 and clr_done=0. Consequently a=0, b=0 and wr_drop=0 while in reset.
- Write (IDLE only): if w=1, reg[da] <= d at the rising edge; the storage update is visible from the next cycle.
- Read: a = reg[sa] and b = reg[sb], combinational.
- Bypass (IDLE only): if w=1 and da==sa, then a=d in the same cycle; likewise b=d if da==sb. Both ports may bypass at once.
- FSM states: IDLE and CLEAR.
  - IDLE -> CLEAR when clr_req=1 at the edge; ptr <= 0.
  - CLEAR: each edge writes reg[ptr] <= 0, then ptr <= ptr+1. The clear takes exactly DEPTH cycles.
  - CLEAR -> IDLE at the edge that zeroes reg[DEPTH-1]. clr_done is registered and high for exactly the first IDLE cycle after the clear.
- clr_busy = 1 exactly while the FSM is in CLEAR (a registered state decode).
- During CLEAR:
  - w is ignored and storage is unchanged by d.
  - wr_drop = w & clr_busy, combinational, same cycle.
  - Bypass is disabled.
  - Reads return current storage, so already-cleared entries read 0 and uncleared entries read their old value.
- clr_req while in CLEAR is ignored; there is no restart or queueing.
- clr_req and w together in IDLE: the write commits at that edge and the clear starts the next cycle, so the written entry ends at 0.
- Reset mid-clear aborts the sequence; every register is 0 regardless, and clr_done does not pulse.
- ptr is AW bits wide and wraps naturally. No other arithmetic.

Optional Feature:
- Macro name: REGFILE_ZERO_REG_EN.
- Defined: register 0 is hardwired to zero.
  - Writes with da==0 are discarded and do not raise wr_drop.
  - Reads of address 0 always return 0, including when w=1 and da==0 (no bypass).
  - The clear sequence still takes DEPTH cycles.
- Undefined: register 0 behaves like any other entry.

Decomposition:
- Shared package regfile_pkg holds:
  - the default DW/AW constants;
  - the FSM state type {ST_IDLE, ST_CLEAR}.
- One natural sub-module: regfile_clr_seq, which owns the FSM, ptr, clr_busy and clr_done, and outputs a clear-write strobe plus address.
- The top level holds the storage array, the write-port mux (user write vs. clear write), the read muxes and the bypass logic.

Test Plan (DW=4, AW=3):
- Reset then read every address on both ports -> a=b=0, clr_busy=0, clr_done=0, wr_drop=0.
- Write d=4'hA to da=3 with sa=3, sb=3 -> a=b=4'hA in the same cycle (bypass); with w=0 the next cycle, a=b=4'hA from storage.
- Fill regs 0..7 with 1..8, then pulse clr_req:
  - clr_busy high for 8 cycles;
  - sa=7 reads 8 until the 8th CLEAR edge, then 0;
  - clr_done is a single pulse in the following cycle.
- Assert w=1, da=2, d=4'h5 during CLEAR -> wr_drop=1 that cycle; reg2 reads 0 after clr_done.
- Drop rst_n low at the 3rd CLEAR cycle -> all outputs 0 immediately; after release, clr_busy=0 and clr_done never pulses.
- With REGFILE_ZERO_REG_EN: write 4'hF to da=0 -> a=0 (sa=0) both in the same cycle and the next cycle; wr_drop=0.
